accum_bank_param: RTL



---
 rtl/accum_bank_param.sv | 139 +++++++++++++
 1 files changed

// File: rtl/accum_bank_param.sv
// Bank of LANES signed DW-bit accumulators, each summing a programmable window of beats.
// Optional macro ACCUM_BANK_SAT_EN: saturating lane adds plus a sticky per-lane sat_flag output.
module accum_bank_param #(
  parameter int LANES = 64,
  parameter int DW    = 16,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  usr_rst,
  input  logic                  in_data_v,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic [LANES-1:0]      lane_en,
  input  logic [CNT_W-1:0]      acc_len,
  output logic                  out_data_v,
  output logic [LANES*DW-1:0]   out_data,
`ifdef ACCUM_BANK_SAT_EN
  output logic [LANES-1:0]      sat_flag,
`endif
  output logic [CNT_W-1:0]      acc_cnt
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t              state, state_d;
  logic [LANES*DW-1:0] acc, acc_d, sum;
  logic [CNT_W-1:0]    len, len_d, cnt, cnt_d;
  logic [CNT_W-1:0]    eff_len, cnt_inc;
  logic                accept;

`ifdef ACCUM_BANK_SAT_EN
  logic [LANES-1:0]    ovf, sat, sat_d;

  // Returns {overflowed, clamped_sum}.
  function automatic logic [DW:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] s;
    logic          o;
    s = a + b;
    o = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
    if (o) s = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return {o, s};
  endfunction

  assign sat_flag = sat;
`endif

  assign accept     = in_data_v && in_ready;
  assign in_ready   = (state != DONE);
  assign out_data_v = (state == DONE);
  assign out_data   = acc;
  assign acc_cnt    = cnt;
  assign eff_len    = (acc_len == '0) ? CNT_W'(1) : acc_len;
  assign cnt_inc    = cnt + CNT_W'(1);

  always_comb begin
    sum = '0;
`ifdef ACCUM_BANK_SAT_EN
    ovf = '0;
`endif
    for (int unsigned i = 0; i < LANES; i++) begin
`ifdef ACCUM_BANK_SAT_EN
      {ovf[i], sum[i*DW +: DW]} = sat_add(acc[i*DW +: DW], in_data[i*DW +: DW]);
`else
      sum[i*DW +: DW] = acc[i*DW +: DW] + in_data[i*DW +: DW];
`endif
    end
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    len_d   = len;
    cnt_d   = cnt;
`ifdef ACCUM_BANK_SAT_EN
    sat_d   = sat;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          len_d = eff_len;
          cnt_d = CNT_W'(1);
`ifdef ACCUM_BANK_SAT_EN
          sat_d = '0;
`endif
          // First beat loads rather than adds; masked lanes start the window at zero.
          for (int unsigned i = 0; i < LANES; i++)
            acc_d[i*DW +: DW] = lane_en[i] ? in_data[i*DW +: DW] : '0;
          state_d = (eff_len == CNT_W'(1)) ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          for (int unsigned i = 0; i < LANES; i++)
            if (lane_en[i]) acc_d[i*DW +: DW] = sum[i*DW +: DW];
`ifdef ACCUM_BANK_SAT_EN
          sat_d = sat | (ovf & lane_en);
`endif
          cnt_d = cnt_inc;
          if (cnt_inc == len) state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (usr_rst) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
`ifdef ACCUM_BANK_SAT_EN
      sat_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      len   <= '0;
      cnt   <= '0;
`ifdef ACCUM_BANK_SAT_EN
      sat   <= '0;
`endif
    end else begin
      state <= state_d;
      acc   <= acc_d;
      len   <= len_d;
      cnt   <= cnt_d;
`ifdef ACCUM_BANK_SAT_EN
      sat   <= sat_d;
`endif
    end
  end

endmodule
